// File: rtl/replay_fifo_pkg.sv
// Shared types and helpers for the replay FIFO: pointer type, default depth
// and the modular pointer-distance function.
package replay_fifo_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF:0] ptr_t;

  // Narrower pointers are zero-extended into ptr_t; the low bits of the
  // difference stay exact, so callers truncate to their own pointer width.
  function automatic ptr_t ptr_dist(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/replay_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port with a
// single cycle of latency. The storage array itself is never reset.
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic              rdEn_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdData_q;

  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Output register holds its value whenever no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/replay_fifo.sv
// In-order buffer whose read side can rewind to the oldest unacknowledged
// entry. This level holds only pointer, flag, count and error state.
module replay_fifo
  import replay_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              commit,
  input  logic              replay,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   used_cnt,
  output logic [ADDR_W:0]   unread_cnt,
  output logic              err
);

  localparam int              PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0] ackPtr_q, ackPtr_d;
  logic [ADDR_W:0] usedCnt_q, usedCnt_d;
  logic [ADDR_W:0] unreadCnt_q, unreadCnt_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            err_q, err_d;
  logic            dataValid_q, dataValid_d;
  logic            doWrite, doRead;

  // Replay overrides both the read and the commit of the same cycle; flags
  // are derived from the next-state pointers so they never lag them.
  always_comb begin
    doWrite     = en & wr & ~full_q;
    doRead      = en & rd & ~empty_q & ~replay;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    ackPtr_d    = ackPtr_q;
    err_d       = 1'b0;
    dataValid_d = doRead;

    if (en) begin
      err_d = (wr & full_q) | (rd & empty_q & ~replay);
      if (doWrite) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (replay) begin
        rdPtr_d = ackPtr_q;
      end else begin
        if (doRead) begin
          rdPtr_d = rdPtr_q + PTR_ONE;
        end
        if (commit) begin
          ackPtr_d = rdPtr_q;
        end
      end
    end

    usedCnt_d   = PTR_W'(ptr_dist(ptr_t'(wrPtr_d), ptr_t'(ackPtr_d)));
    unreadCnt_d = PTR_W'(ptr_dist(ptr_t'(wrPtr_d), ptr_t'(rdPtr_d)));
    full_d      = (usedCnt_d == FULL_CNT);
    empty_d     = (wrPtr_d == rdPtr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      ackPtr_q    <= '0;
      usedCnt_q   <= '0;
      unreadCnt_q <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_q       <= 1'b0;
      dataValid_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      ackPtr_q    <= ackPtr_d;
      usedCnt_q   <= usedCnt_d;
      unreadCnt_q <= unreadCnt_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      err_q       <= err_d;
      dataValid_q <= dataValid_d;
    end
  end

  sdp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .wrEn_i  (doWrite),
    .wrAddr_i(wrPtr_q[ADDR_W-1:0]),
    .wrData_i(data_in),
    .rdEn_i  (doRead),
    .rdAddr_i(rdPtr_q[ADDR_W-1:0]),
    .rdData_o(data_out)
  );

  assign data_valid = dataValid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign used_cnt   = usedCnt_q;
  assign unread_cnt = unreadCnt_q;
  assign err        = err_q;

endmodule
